// File: rtl/piezo_pulse_detector_pkg.sv
// Shared types and helpers for the piezo pulse detector.
// FSM encoding, statistics width and saturating arithmetic.
package piezo_pulse_detector_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_QUALIFY  = 3'd1,
        ST_ACTIVE   = 3'd2,
        ST_HOLDOFF  = 3'd3,
        ST_WAIT_LOW = 3'd4
    } state_e;

    localparam int STAT_W = 16;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    function automatic logic [STAT_W-1:0] sat_inc(
        input logic [STAT_W-1:0] v,
        input logic [STAT_W-1:0] lim
    );
        return (v >= lim) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/piezo_pulse_detector_sync_chain.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
// Reusable for any async line entering the time-sync clock domain.
module piezo_pulse_detector_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/piezo_pulse_detector.sv
// Piezo hit detector: sync, glitch reject, fixed pulse, hold-off,
// timestamp and saturating event/glitch statistics.
module piezo_pulse_detector
    import piezo_pulse_detector_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_WIDTH   = 4,
    parameter int OUT_LEN     = 6,
    parameter int HOLDOFF     = 64,
    parameter int TS_W        = 32,
    parameter logic [STAT_W-1:0] SAT_MAX = STAT_MAX
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear_stats,
    input  logic              piezo_raw_in,
    output logic              pulse_out,
    output logic              pulse_valid,
    output logic [TS_W-1:0]   timestamp,
    output logic [STAT_W-1:0] event_count,
    output logic [STAT_W-1:0] glitch_count,
    output logic              busy
);

    localparam int MAX_A   = (HOLDOFF > OUT_LEN) ? HOLDOFF : OUT_LEN;
    localparam int CNT_MAX = (MAX_A > MIN_WIDTH) ? MAX_A : MIN_WIDTH;
    localparam int CW      = $clog2(CNT_MAX + 1) + 1;

    localparam logic [CW-1:0] Q_LAST = CW'(MIN_WIDTH - 1);
    localparam logic [CW-1:0] O_LAST = CW'(OUT_LEN);
    localparam logic [CW-1:0] H_LAST = CW'(HOLDOFF);
    localparam logic [CW-1:0] ONE    = CW'(1);

    logic              s;
    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic [TS_W-1:0]   timebase_q;
    logic [TS_W-1:0]   ts_hold_q;
    logic [TS_W-1:0]   stamp_q;
    logic              pulse_q;
    logic              valid_q;
    logic              busy_q;
    logic [STAT_W-1:0] event_q, event_d;
    logic [STAT_W-1:0] glitch_q, glitch_d;
    logic              hit;
    logic              glitch;

    piezo_pulse_detector_sync_chain #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clock(clock),
        .reset(reset),
        .d_i  (piezo_raw_in),
        .q_o  (s)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timebase_q <= '0;
        end else begin
            timebase_q <= timebase_q + TS_W'(1);
        end
    end

    always_comb begin
        hit    = 1'b0;
        glitch = 1'b0;
        if (enable) begin
            unique case (state_q)
                ST_IDLE: begin
                    hit = s && (MIN_WIDTH == 1);
                end
                ST_QUALIFY: begin
                    hit    = s && (cnt_q == Q_LAST);
                    glitch = !s;
                end
                default: ;
            endcase
        end
    end

    // Clear wins over a same-cycle increment; that cycle's event is lost.
    always_comb begin
        event_d  = hit ? sat_inc(event_q, SAT_MAX) : event_q;
        glitch_d = glitch ? sat_inc(glitch_q, SAT_MAX) : glitch_q;
        if (clear_stats) begin
            event_d  = '0;
            glitch_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            event_q  <= '0;
            glitch_q <= '0;
        end else begin
            event_q  <= event_d;
            glitch_q <= glitch_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ts_hold_q <= '0;
            stamp_q   <= '0;
            pulse_q   <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            busy_q  <= (state_q != ST_IDLE);
            valid_q <= 1'b0;
            if (!enable) begin
                state_q <= ST_IDLE;
                pulse_q <= 1'b0;
            end else if (hit) begin
                pulse_q <= 1'b1;
                valid_q <= 1'b1;
                stamp_q <= (state_q == ST_IDLE) ? timebase_q : ts_hold_q;
                cnt_q   <= ONE;
                state_q <= ST_ACTIVE;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (s) begin
                            ts_hold_q <= timebase_q;
                            cnt_q     <= ONE;
                            state_q   <= ST_QUALIFY;
                        end
                    end
                    ST_QUALIFY: begin
                        if (!s) state_q <= ST_IDLE;
                        else    cnt_q   <= cnt_q + ONE;
                    end
                    ST_ACTIVE: begin
                        if (cnt_q == O_LAST) begin
                            pulse_q <= 1'b0;
                            cnt_q   <= ONE;
                            state_q <= (HOLDOFF == 0) ? ST_WAIT_LOW
                                                      : ST_HOLDOFF;
                        end else begin
                            cnt_q <= cnt_q + ONE;
                        end
                    end
                    ST_HOLDOFF: begin
                        if (cnt_q == H_LAST) state_q <= ST_WAIT_LOW;
                        else                 cnt_q   <= cnt_q + ONE;
                    end
                    ST_WAIT_LOW: begin
                        if (!s) state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign pulse_out    = pulse_q;
    assign pulse_valid  = valid_q;
    assign timestamp    = stamp_q;
    assign event_count  = event_q;
    assign glitch_count = glitch_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_piezo_pulse_detector.sv
// Bench for piezo_pulse_detector: vector table, corner sequences,
// and random bursts against an interval-based reference model.
module tb_piezo_pulse_detector;

    localparam int MIN_W = 4;
    localparam int OLEN  = 6;
    localparam int HOLD  = 64;
    localparam int N     = 3000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b1;
    logic clear_stats = 1'b0;
    logic piezo_raw_in = 1'b0;

    logic        pulse_out, pulse_valid, busy;
    logic [31:0] timestamp;
    logic [15:0] event_count, glitch_count;
    logic        s_pulse_out, s_pulse_valid, s_busy;
    logic [31:0] s_timestamp;
    logic [15:0] s_ev, s_gl;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    piezo_pulse_detector dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .clear_stats (clear_stats),
        .piezo_raw_in(piezo_raw_in),
        .pulse_out   (pulse_out),
        .pulse_valid (pulse_valid),
        .timestamp   (timestamp),
        .event_count (event_count),
        .glitch_count(glitch_count),
        .busy        (busy)
    );

    piezo_pulse_detector #(
        .SAT_MAX(16'd15)
    ) dut_sat (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .clear_stats (clear_stats),
        .piezo_raw_in(piezo_raw_in),
        .pulse_out   (s_pulse_out),
        .pulse_valid (s_pulse_valid),
        .timestamp   (s_timestamp),
        .event_count (s_ev),
        .glitch_count(s_gl),
        .busy        (s_busy)
    );

    typedef struct {
        int   r0;
        int   r1;
        int   at;
        logic po;
        logic pv;
        logic bz;
        int   ev;
        int   gl;
        int   ts;
    } vec_t;

    vec_t vt[13];

    logic        raw_a[N];
    logic [66:0] got_a[N];
    logic        s_a[N];
    logic        epo[N];
    logic        epv[N];
    logic        nidle[N];
    int          evi[N];
    int          gli[N];
    int          tsa[N];

    task automatic chk(input string name, input logic [95:0] got,
                       input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        piezo_raw_in = 1'b0;
        enable = 1'b1;
        clear_stats = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic step(input logic raw, input logic en, input logic clr);
        piezo_raw_in = raw;
        enable = en;
        clear_stats = clr;
        @(posedge clock);
        #1;
    endtask

    function automatic logic win(input int e, input int a, input int b);
        return (e >= a) && (e <= b);
    endfunction

    function automatic logic [66:0] outs();
        return {pulse_out, pulse_valid, busy, event_count,
                glitch_count, timestamp};
    endfunction

    int idx, k, r, h, j, ec, gc, tsv, spurious;

    initial begin
        vt[0]  = '{10, 30,  14, 0, 0, 1, 0, 0, 0};
        vt[1]  = '{10, 30,  15, 1, 1, 1, 1, 0, 12};
        vt[2]  = '{10, 30,  16, 1, 0, 1, 1, 0, 12};
        vt[3]  = '{10, 30,  20, 1, 0, 1, 1, 0, 12};
        vt[4]  = '{10, 30,  21, 0, 0, 1, 1, 0, 12};
        vt[5]  = '{10, 12,  15, 0, 0, 1, 0, 1, 0};
        vt[6]  = '{10, 12,  16, 0, 0, 0, 0, 1, 0};
        vt[7]  = '{10, 12,  12, 0, 0, 0, 0, 0, 0};
        vt[8]  = '{10, 13,  15, 1, 1, 1, 1, 0, 12};
        vt[9]  = '{10, 200, 150, 0, 0, 1, 1, 0, 12};
        vt[10] = '{10, 200, 203, 0, 0, 1, 1, 0, 12};
        vt[11] = '{10, 200, 204, 0, 0, 0, 1, 0, 12};
        vt[12] = '{10, 10,  14, 0, 0, 0, 0, 1, 0};

        do_reset();
        chk("reset_state", 96'(outs()), 96'(0));

        for (int i = 0; i < 13; i++) begin
            do_reset();
            for (int e = 0; e <= vt[i].at; e++) begin
                step(win(e, vt[i].r0, vt[i].r1), 1'b1, 1'b0);
            end
            chk($sformatf("vec%0d.pulse_out", i), 96'(pulse_out),
                96'(vt[i].po));
            chk($sformatf("vec%0d.pulse_valid", i), 96'(pulse_valid),
                96'(vt[i].pv));
            chk($sformatf("vec%0d.busy", i), 96'(busy), 96'(vt[i].bz));
            chk($sformatf("vec%0d.event_count", i), 96'(event_count),
                96'(vt[i].ev));
            chk($sformatf("vec%0d.glitch_count", i), 96'(glitch_count),
                96'(vt[i].gl));
            chk($sformatf("vec%0d.timestamp", i), 96'(timestamp),
                96'(vt[i].ts));
        end

        // Second burst lands inside hold-off and must be ignored.
        do_reset();
        spurious = 0;
        for (int e = 0; e <= 110; e++) begin
            step(win(e, 10, 13) | win(e, 40, 43) | win(e, 100, 103),
                 1'b1, 1'b0);
            if (e >= 22 && e <= 99 && pulse_out) spurious++;
            if (e == 84) chk("two.busy84", 96'(busy), 96'(1));
            if (e == 86) chk("two.busy86", 96'(busy), 96'(1));
            if (e == 87) chk("two.busy87", 96'(busy), 96'(0));
            if (e == 105) begin
                chk("two.pulse105", 96'(pulse_out), 96'(1));
                chk("two.events", 96'(event_count), 96'(2));
                chk("two.timestamp", 96'(timestamp), 96'(102));
            end
        end
        chk("two.no_pulse_in_holdoff", 96'(spurious), 96'(0));

        // Enable drop truncates a pulse in flight.
        do_reset();
        for (int e = 0; e <= 50; e++) begin
            step(win(e, 10, 13) | win(e, 40, 43), !win(e, 18, 25), 1'b0);
            if (e == 17) chk("en.pulse17", 96'(pulse_out), 96'(1));
            if (e == 18) begin
                chk("en.pulse18", 96'(pulse_out), 96'(0));
                chk("en.events18", 96'(event_count), 96'(1));
            end
            if (e == 19) chk("en.busy19", 96'(busy), 96'(0));
            if (e == 45) begin
                chk("en.rehit_valid", 96'(pulse_valid), 96'(1));
                chk("en.rehit_events", 96'(event_count), 96'(2));
                chk("en.rehit_ts", 96'(timestamp), 96'(42));
            end
        end

        // Clear in the same cycle as a hit.
        do_reset();
        for (int e = 0; e <= 110; e++) begin
            step(win(e, 2, 3) | win(e, 10, 13) | win(e, 100, 103),
                 1'b1, e == 15);
            if (e == 7) chk("clr.glitch7", 96'(glitch_count), 96'(1));
            if (e == 15) begin
                chk("clr.events", 96'(event_count), 96'(0));
                chk("clr.glitches", 96'(glitch_count), 96'(0));
                chk("clr.timestamp", 96'(timestamp), 96'(12));
                chk("clr.pulse", 96'(pulse_out), 96'(1));
            end
            if (e == 105) begin
                chk("clr.events105", 96'(event_count), 96'(1));
                chk("clr.ts105", 96'(timestamp), 96'(102));
            end
        end

        // Asynchronous reset in the middle of a pulse.
        do_reset();
        for (int e = 0; e <= 16; e++) step(win(e, 10, 30), 1'b1, 1'b0);
        chk("arst.pulse_before", 96'(pulse_out), 96'(1));
        #1 reset = 1'b1;
        #1 chk("arst.outputs", 96'(outs()), 96'(0));

        // Saturation against a low ceiling instance.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0);
            step(1'b0, 1'b1, 1'b0);
        end
        repeat (10) step(1'b0, 1'b1, 1'b0);
        chk("sat.glitch_main", 96'(glitch_count), 96'(20));
        chk("sat.glitch_ceiling", 96'(s_gl), 96'(15));
        for (int i = 0; i < 17; i++) begin
            repeat (4) step(1'b1, 1'b1, 1'b0);
            repeat (90) step(1'b0, 1'b1, 1'b0);
        end
        chk("sat.event_main", 96'(event_count), 96'(17));
        chk("sat.event_ceiling", 96'(s_ev), 96'(15));

        // Random bursts; tail kept low so every burst resolves.
        for (int e = 0; e < N; e++) raw_a[e] = 1'b0;
        idx = int'($urandom_range(5, 40));
        while (idx < N - 300) begin
            k = int'($urandom_range(0, 9));
            if (k < 4)      r = int'($urandom_range(1, 3));
            else if (k < 9) r = int'($urandom_range(4, 10));
            else            r = int'($urandom_range(60, 150));
            for (int e = 0; e < r; e++) raw_a[idx + e] = 1'b1;
            idx = idx + r + int'($urandom_range(1, 90));
        end

        do_reset();
        for (int e = 0; e < N; e++) begin
            step(raw_a[e], 1'b1, 1'b0);
            got_a[e] = outs();
        end

        for (int e = 0; e < N; e++) begin
            s_a[e]   = (e >= 2) ? raw_a[e-2] : 1'b0;
            epo[e]   = 1'b0;
            epv[e]   = 1'b0;
            nidle[e] = 1'b0;
            evi[e]   = 0;
            gli[e]   = 0;
            tsa[e]   = -1;
        end
        idx = 0;
        while (idx < N) begin
            if (!s_a[idx]) begin
                idx++;
            end else begin
                k = idx;
                r = 0;
                while (k + r < N && s_a[k+r]) r++;
                if (r < MIN_W) begin
                    for (int e = k; e < k + r; e++) nidle[e] = 1'b1;
                    if (k + r < N) gli[k+r] = 1;
                    idx = k + r + 1;
                end else begin
                    h = k + MIN_W - 1;
                    evi[h] = 1;
                    tsa[h] = k;
                    epv[h] = 1'b1;
                    for (int e = h; e < h + OLEN && e < N; e++)
                        epo[e] = 1'b1;
                    j = h + OLEN + HOLD + 1;
                    while (j < N && s_a[j]) j++;
                    for (int e = k; e < j && e < N; e++) nidle[e] = 1'b1;
                    idx = j + 1;
                end
            end
        end

        ec = 0;
        gc = 0;
        tsv = 0;
        for (int e = 0; e < N; e++) begin
            ec += evi[e];
            gc += gli[e];
            if (tsa[e] >= 0) tsv = tsa[e];
            chk($sformatf("rand.edge%0d", e), 96'(got_a[e]),
                96'({epo[e], epv[e], (e > 0) ? nidle[e-1] : 1'b0,
                     16'(ec), 16'(gc), 32'(tsv)}));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piezo_pulse_detector.md
Name: piezo_pulse_detector

Overview:
- Conditions the raw piezo comparator line before it reaches the time-sync master/slave pair (drives their piezo input).
- Synchronises the raw line, rejects glitches shorter than MIN_WIDTH, and emits a clean fixed-length pulse per qualified hit.
- Blanks acoustic ringing with a hold-off window after each hit.
- Timestamps each hit against a free-running timebase; keeps event and glitch statistics for HPS readout.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in the input synchroniser (>=2).
- MIN_WIDTH, 4, consecutive synchronised high samples needed to qualify a hit (>=1).
- OUT_LEN, 6, cycles pulse_out stays high per hit (>=1).
- HOLDOFF, 64, blanking cycles after pulse_out falls (>=0).
- TS_W, 32, timebase/timestamp width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- enable  in  1  detector enable; low forces IDLE
- clear_stats  in  1  synchronous clear of event_count/glitch_count
- piezo_raw_in  in  1  asynchronous comparator output
- pulse_out  out  1  qualified pulse, OUT_LEN cycles, to PTP master/slave input
- pulse_valid  out  1  one-cycle strobe, first cycle of pulse_out
- timestamp  out  TS_W  timebase value at first high sample of last qualified hit
- event_count  out  16  qualified hits, saturating
- glitch_count  out  16  rejected short pulses, saturating
- busy  out  1  high in any state except IDLE

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clock. All outputs registered.
- Reset values: pulse_out=0, pulse_valid=0, timestamp=0, event_count=0, glitch_count=0, busy=0, timebase=0, state=IDLE, synchroniser cleared.
- Synchroniser: s = piezo_raw_in delayed by SYNC_STAGES flops.
- Timebase: free-running TS_W counter, +1 every cycle from reset, wraps to 0. Runs regardless of enable.
- FSM states: IDLE, QUALIFY, ACTIVE, HOLDOFF, WAIT_LOW.
- IDLE: at an edge with s=1, latch ts_hold=timebase and qcnt=1.
  - If MIN_WIDTH=1, go directly to ACTIVE (hit actions below).
  - Otherwise go to QUALIFY.
- QUALIFY:
  - s=0: glitch_count+1, go to IDLE.
  - s=1 and qcnt<MIN_WIDTH-1: qcnt+1.
  - s=1 and qcnt=MIN_WIDTH-1: hit.
- Hit actions (same edge): pulse_out<=1, pulse_valid<=1, timestamp<=ts_hold, event_count+1, ocnt=1, go to ACTIVE.
  - Latency: pulse_out rises at the edge of the MIN_WIDTH-th consecutive high sample of s.
- ACTIVE: pulse_valid<=0. After OUT_LEN cycles high, pulse_out<=0 and go to HOLDOFF (HOLDOFF=0: go straight to WAIT_LOW). s is ignored.
- HOLDOFF: count HOLDOFF cycles, s ignored, then go to WAIT_LOW.
- WAIT_LOW: stay while s=1; at an edge with s=0 go to IDLE. This prevents re-triggering on a held-high line.
- enable=0: next edge forces IDLE, pulse_out=0, pulse_valid=0. Counters and timestamp hold. A pulse in flight is truncated and not counted again.
- clear_stats: has priority over same-cycle increments; both counts read 0 on the next cycle and that cycle's event/glitch is dropped. timestamp is not cleared.
- Saturation: counts stop at 16'hFFFF.
- Timebase wrap: timestamp is a plain snapshot; consumers handle wrap by modular subtraction.
- Async reset mid-pulse: all outputs return to reset values immediately.

Decomposition:
- Shared package: FSM state encoding (3-bit enum), stat counter width 16, saturating-increment function.
- One natural sub-module: sync_chain (parameterised SYNC_STAGES flop chain with async reset), reusable for other async inputs of the time-sync block.

Test Plan (defaults, edge 0 = first edge after reset release):
- Raw high at edges 10..30 -> s high from edge 12; pulse_out high edges 15..20 (6 cycles); pulse_valid only at edge 15; timestamp=12; event_count=1.
- Raw high for 3 cycles at edges 10..12 -> no pulse_out; glitch_count=1; busy back to 0 at edge 16.
- Two hits: raw high edges 10..13, low, then high again at edge 40 -> second hit ignored (HOLDOFF until edge 84); raw high again at edges 100..103 -> event_count=2, timestamp=102.
- Raw stuck high from edge 10 to 200 -> exactly one hit; busy stays 1 until s falls, then IDLE.
- enable dropped at edge 17 mid-pulse -> pulse_out low from edge 18; event_count stays 1; next hit after re-enable is detected normally.
- clear_stats in the same cycle as a hit -> event_count=0 next cycle, timestamp still updated. Separately, force 65536 glitches -> glitch_count saturates at 16'hFFFF.
